// File: rtl/maxnet_pkg.sv
// Shared constants and FSM encoding for the 4-neuron MaxNet loader.
// Sizing is fixed at four neurons; only the data width is a parameter of the top.
package maxnet_pkg;

   localparam int N_NEURONS     = 4;
   localparam int IDX_W         = 2;
   localparam int DEFAULT_WIDTH = 10;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_LOAD   = 2'd0;
   localparam logic [STATE_W-1:0] ST_START  = 2'd1;
   localparam logic [STATE_W-1:0] ST_RUN    = 2'd2;
   localparam logic [STATE_W-1:0] ST_REPORT = 2'd3;

   typedef logic [IDX_W-1:0]     idx_t;
   typedef logic [N_NEURONS-1:0] onehot_t;

endpackage

// File: rtl/index_decoder.sv
// 2-to-4 one-hot decoder, purely combinational (zero latency).
// Used for both slot load enables and the reported winner.
module index_decoder
   import maxnet_pkg::*;
(
   input  logic [IDX_W-1:0]     idx,
   output logic [N_NEURONS-1:0] onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/maxnet_loader.sv
// MaxNet loader: four handshaked words -> x1..x4, start pulse, wait finish, report winner.
// Latency: x updates on the accept edge; start one cycle after 4th accept; result one cycle after finish.
// Backpressure: in_ready only in LOAD; MAXNET_LOADER_SM_CONV_EN enables sign-magnitude input conversion.
module maxnet_loader
   import maxnet_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic [N_NEURONS-1:0] load_en,
   output logic [WIDTH-1:0]     x1,
   output logic [WIDTH-1:0]     x2,
   output logic [WIDTH-1:0]     x3,
   output logic [WIDTH-1:0]     x4,
   output logic                 start,
   input  logic                 finish,
   input  logic [IDX_W-1:0]     winner_idx,
   output logic                 result_valid,
   output logic [N_NEURONS-1:0] winner_onehot,
   output logic [WIDTH-1:0]     winner_value
);

   logic [STATE_W-1:0]  state;
   logic [STATE_W-1:0]  state_nxt;
   idx_t                cnt;
   logic [WIDTH-1:0]    raw [N_NEURONS];
   logic [WIDTH-1:0]    conv_dat;
   logic                xfer;
   logic                win_take;
   onehot_t             cnt_dec;
   onehot_t             win_dec;

   index_decoder u_load_dec (
      .idx    (cnt),
      .onehot (cnt_dec)
   );

   index_decoder u_win_dec (
      .idx    (winner_idx),
      .onehot (win_dec)
   );

   assign in_ready     = (state == ST_LOAD);
   assign xfer         = in_valid && in_ready;
   assign load_en      = xfer ? cnt_dec : '0;
   assign start        = (state == ST_START);
   assign result_valid = (state == ST_REPORT);
   // finish is only trusted in RUN: the done checker flags all-zero registers as done.
   assign win_take     = (state == ST_RUN) && finish;

`ifdef MAXNET_LOADER_SM_CONV_EN
   // Negative zero falls out naturally: 0 - 0 = 0.
   assign conv_dat = in_data[WIDTH-1] ? ({WIDTH{1'b0}} - {1'b0, in_data[WIDTH-2:0]})
                                      : in_data;
`else
   assign conv_dat = in_data;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:   if (xfer && (cnt == idx_t'(N_NEURONS - 1))) state_nxt = ST_START;
         ST_START:  state_nxt = ST_RUN;
         ST_RUN:    if (finish) state_nxt = ST_REPORT;
         ST_REPORT: state_nxt = ST_LOAD;
         default:   state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_LOAD;
         cnt           <= '0;
         x1            <= '0;
         x2            <= '0;
         x3            <= '0;
         x4            <= '0;
         winner_onehot <= '0;
         winner_value  <= '0;
         for (int i = 0; i < N_NEURONS; i++) raw[i] <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            cnt      <= cnt + 1'b1;
            raw[cnt] <= in_data;
            if (cnt_dec[0]) x1 <= conv_dat;
            if (cnt_dec[1]) x2 <= conv_dat;
            if (cnt_dec[2]) x3 <= conv_dat;
            if (cnt_dec[3]) x4 <= conv_dat;
         end
         if (win_take) begin
            winner_onehot <= win_dec;
            winner_value  <= raw[winner_idx];
         end
      end
   end

endmodule

// File: tb/tb_maxnet_loader.sv
// Table-driven bench for maxnet_loader with a result scoreboard.
module tb_maxnet_loader;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] in_data;
   logic [3:0] load_en;
   logic [9:0] x1, x2, x3, x4;
   logic       start;
   logic       finish;
   logic [1:0] winner_idx;
   logic       result_valid;
   logic [3:0] winner_onehot;
   logic [9:0] winner_value;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0][9:0] w;
      logic [3:0][9:0] ex;
      logic [1:0]      widx;
      logic [3:0]      wait_cyc;
      logic            gaps;
      logic            early_fin;
   } vec_t;

   typedef struct packed {
      logic [3:0] oh;
      logic [9:0] val;
   } res_t;

   vec_t tbl [6];
   res_t sb [$];

   maxnet_loader #(.WIDTH(10)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .load_en       (load_en),
      .x1            (x1),
      .x2            (x2),
      .x3            (x3),
      .x4            (x4),
      .start         (start),
      .finish        (finish),
      .winner_idx    (winner_idx),
      .result_valid  (result_valid),
      .winner_onehot (winner_onehot),
      .winner_value  (winner_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] get_x(input int i);
      case (i)
         0:       return x1;
         1:       return x2;
         2:       return x3;
         default: return x4;
      endcase
   endfunction

   function automatic logic [39:0] mk(input logic [9:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   // Scoreboard consumer: every result_valid must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && result_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result_valid: got 1 want 0");
         end else begin
            res_t e;
            e = sb.pop_front();
            chk("winner_onehot", 32'(winner_onehot), 32'(e.oh));
            chk("winner_value", 32'(winner_value), 32'(e.val));
         end
      end
   end

   task automatic run_round(input vec_t v);
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << v.widx;
      if (v.early_fin) begin
         finish     = 1'b1;
         winner_idx = v.widx;
      end
      chk("ready_idle", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (v.gaps) begin
            in_valid = 1'b0;
            #1;
            chk("gap_load_en", 32'(load_en), 32'd0);
            tick();
         end
         in_valid = 1'b1;
         in_data  = v.w[i];
         #1;
         chk($sformatf("load_en_slot%0d", i), 32'(load_en), 32'(4'b0001 << i));
         chk("rv_load", 32'(result_valid), 32'd0);
         tick();
         chk($sformatf("x%0d", i + 1), 32'(get_x(i)), 32'(v.ex[i]));
      end
      // Source keeps offering garbage while the loader is busy; it must be ignored.
      in_data = 10'h155;
      #1;
      chk("start_pulse", 32'(start), 32'd1);
      chk("ready_start", 32'(in_ready), 32'd0);
      chk("load_en_start", 32'(load_en), 32'd0);
      chk("rv_start", 32'(result_valid), 32'd0);
      tick();
      chk("start_drop", 32'(start), 32'd0);
      for (int c = 0; c < int'(v.wait_cyc); c++) begin
         chk("ready_run", 32'(in_ready), 32'd0);
         chk("load_en_run", 32'(load_en), 32'd0);
         chk("rv_run", 32'(result_valid), 32'd0);
         tick();
      end
      in_valid   = 1'b0;
      finish     = 1'b1;
      winner_idx = v.widx;
      sb.push_back('{oh: exp_oh, val: v.w[v.widx]});
      tick();
      finish     = 1'b0;
      winner_idx = ~v.widx;
      #1;
      chk("result_valid", 32'(result_valid), 32'd1);
      chk("ready_report", 32'(in_ready), 32'd0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("x%0d_hold", i + 1), 32'(get_x(i)), 32'(v.ex[i]));
      tick();
      chk("rv_drop", 32'(result_valid), 32'd0);
      chk("ready_back", 32'(in_ready), 32'd1);
      chk("onehot_held", 32'(winner_onehot), 32'(exp_oh));
      chk("value_held", 32'(winner_value), 32'(v.w[v.widx]));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{w: mk(10'h005, 10'h003, 10'h007, 10'h001), ex: mk(10'h005, 10'h003, 10'h007, 10'h001),
                 widx: 2'd2, wait_cyc: 4'd6, gaps: 1'b0, early_fin: 1'b0};
`ifdef MAXNET_LOADER_SM_CONV_EN
      tbl[1] = '{w: mk(10'h205, 10'h200, 10'h010, 10'h3FF), ex: mk(10'h3FB, 10'h000, 10'h010, 10'h201),
                 widx: 2'd0, wait_cyc: 4'd1, gaps: 1'b0, early_fin: 1'b0};
`else
      tbl[1] = '{w: mk(10'h205, 10'h200, 10'h010, 10'h3FF), ex: mk(10'h205, 10'h200, 10'h010, 10'h3FF),
                 widx: 2'd0, wait_cyc: 4'd1, gaps: 1'b0, early_fin: 1'b0};
`endif
      tbl[2] = '{w: mk(10'h000, 10'h000, 10'h000, 10'h000), ex: mk(10'h000, 10'h000, 10'h000, 10'h000),
                 widx: 2'd0, wait_cyc: 4'd2, gaps: 1'b0, early_fin: 1'b0};
      tbl[3] = '{w: mk(10'h0AA, 10'h011, 10'h1FF, 10'h100), ex: mk(10'h0AA, 10'h011, 10'h1FF, 10'h100),
                 widx: 2'd1, wait_cyc: 4'd0, gaps: 1'b0, early_fin: 1'b1};
      tbl[4] = '{w: mk(10'h020, 10'h021, 10'h022, 10'h023), ex: mk(10'h020, 10'h021, 10'h022, 10'h023),
                 widx: 2'd3, wait_cyc: 4'd3, gaps: 1'b1, early_fin: 1'b0};
      tbl[5] = '{w: mk(10'h031, 10'h032, 10'h033, 10'h034), ex: mk(10'h031, 10'h032, 10'h033, 10'h034),
                 widx: 2'd2, wait_cyc: 4'd1, gaps: 1'b0, early_fin: 1'b0};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      finish     = 1'b0;
      winner_idx = '0;
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_result_valid", 32'(result_valid), 32'd0);
      chk("rst_load_en", 32'(load_en), 32'd0);
      chk("rst_x1", 32'(x1), 32'd0);
      chk("rst_x4", 32'(x4), 32'd0);
      chk("rst_onehot", 32'(winner_onehot), 32'd0);
      chk("rst_value", 32'(winner_value), 32'd0);
      #10;
      rst_n = 1'b1;
      tick();

      for (int t = 0; t < 5; t++) run_round(tbl[t]);

      // Reset after two accepted words discards the partial load.
      in_valid = 1'b1;
      in_data  = 10'h0F0;
      #1;
      chk("pre_rst_load_en0", 32'(load_en), 32'd1);
      tick();
      in_data = 10'h0F1;
      #1;
      chk("pre_rst_load_en1", 32'(load_en), 32'd2);
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_x1", 32'(x1), 32'd0);
      chk("mid_rst_x2", 32'(x2), 32'd0);
      chk("mid_rst_onehot", 32'(winner_onehot), 32'd0);
      chk("mid_rst_value", 32'(winner_value), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_round(tbl[5]);

      repeat (2) tick();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
